truth_table_sequencer: RTL
==========================

// Module: truth_table_sequencer
// PURPOSE
//   Stimulus/capture stage wrapped around a combinational gate lab block
//   (e.g. nand_gate_3input). On start, drives every input combination
//   0..2^N_IN-1 for DWELL cycles each and samples the gate output at the end
//   of each dwell. It builds the observed truth table and scores it against
//   EXPECTED, giving a pass flag and a mismatch count.
// PARAMETERS
//   N_IN      3        gate input count; pattern width; table has 2^N_IN entries
//   DWELL     10       cycles each pattern is held (>=1)
//   EXPECTED  8'h7F    expected table; bit i = expected out for pattern i (NAND3)
// PORTS
//   clk          in   1          single clock; all state updates on rising edge
//   rst          in   1          synchronous, active-high reset
//   start        in   1          begin run; honoured only in IDLE
//   pattern      out  N_IN       gate inputs; pattern[N_IN-1]=a ... pattern[0]=c
//   pattern_vld  out  1          high while pattern is being driven
//   dut_out      in   1          gate output (combinational from pattern)
//   busy         out  1          high in DRIVE and DONE
//   done         out  1          one-cycle pulse at end of run
//   table        out  2^N_IN     captured truth table; bit i = dut_out for pattern i
//   pass         out  1          table==EXPECTED for last completed run
//   err_cnt      out  N_IN+1     number of mismatching entries in last run
// BEHAVIOUR
//   - Reset: state=IDLE; pattern=0, pattern_vld=0, busy=0, done=0, table=0,
//     pass=0, err_cnt=0, dwell counter=0. rst overrides start in the same cycle.
//   - FSM states: IDLE, DRIVE, DONE.
//   - IDLE: start=1 at edge -> DRIVE. Same edge: pattern=0, cnt=0,
//     table=0, err_cnt=0, pass=0. start=0 -> stay in IDLE.
//   - DRIVE: pattern_vld=1, busy=1; cnt increments every cycle.
//     Capture cycle cnt==DWELL-1 -> at that edge table[pattern]<=dut_out.
//     err_cnt increments if dut_out!=EXPECTED[pattern]. If pattern==2^N_IN-1,
//     go to DONE. Otherwise pattern++ and cnt=0.
//   - Each pattern is held exactly DWELL cycles. Full run is 2^N_IN*DWELL
//     DRIVE cycles (80 at defaults), then 1 DONE cycle.
//   - DONE: one cycle; done=1, busy=1, pattern_vld=0, pattern=0. pass is
//     valid from this cycle and reflects the final table incl. last capture.
//     Next edge -> IDLE unconditionally.
//   - start in DRIVE or DONE is ignored; no queuing, no restart.
//   - table, pass and err_cnt hold their values in IDLE until the next
//     accepted start clears them.
//   - Pattern counter never wraps inside a run; last index ends the run.
//   - DWELL=1: pattern changes every cycle; capture every cycle.
//   - rst mid-run: next cycle matches the reset state exactly. No done
//     pulse; partial table is discarded.
//   - err_cnt width N_IN+1 holds the max value 2^N_IN without overflow.
// TESTING
//   1 correct NAND3, start pulse -> pattern 0..7, 10 cycles each; done at
//     cycle 81 after start; table=8'h7F, pass=1, err_cnt=0.
//   2 dut_out stuck at 0 -> table=8'h00, pass=0, err_cnt=7.
//   3 dut_out tied to AND3 -> table=8'h80, pass=0, err_cnt=8 (no overflow).
//   4 start re-pulsed at DRIVE cycle 30 and during DONE -> ignored;
//     single done pulse; results match scenario 1.
//   5 rst asserted at DRIVE cycle 45 with start=1 -> next cycle all outputs
//     at reset values; no done pulse; new start runs the full sequence.
//   6 DWELL=1 instance -> pattern steps each cycle; done 9 cycles after
//     start edge; table=8'h7F, pass=1.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks every input pattern of a combinational gate,
// holds each for DWELL cycles, captures the gate output at the end of each
// dwell and scores the captured table against an expected table.
module truth_table_sequencer #(
    parameter int unsigned         N_IN     = 3,
    parameter int unsigned         DWELL    = 10,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'h7F
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [N_IN-1:0]       pattern_o,
    output logic                  pattern_vld_o,
    input  logic                  dut_out_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [(1<<N_IN)-1:0]  table_o,
    output logic                  pass_o,
    output logic [N_IN:0]         err_cnt_o
);

    localparam int unsigned N_PAT = 1 << N_IN;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [N_IN-1:0]    pattern_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_PAT-1:0]   table_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic               pass_q;
    logic               vld_q;
    logic               busy_q;
    logic               done_q;

    logic [N_PAT-1:0]   table_d;
    logic [ERR_W-1:0]   err_cnt_d;
    logic               last_cnt_c;
    logic               last_pat_c;

    // Table and error count as they will look after capturing the current pattern
    always_comb begin
        table_d            = table_q;
        table_d[pattern_q] = dut_out_i;
        err_cnt_d          = err_cnt_q + ERR_W'(dut_out_i != EXPECTED[pattern_q]);
        last_cnt_c         = (cnt_q == CNT_W'(DWELL - 1));
        last_pat_c         = (pattern_q == N_IN'(N_PAT - 1));
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            cnt_q     <= '0;
            table_q   <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_DRIVE;
                        pattern_q <= '0;
                        cnt_q     <= '0;
                        table_q   <= '0;
                        err_cnt_q <= '0;
                        pass_q    <= 1'b0;
                        vld_q     <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (last_cnt_c) begin
                        table_q   <= table_d;
                        err_cnt_q <= err_cnt_d;
                        cnt_q     <= '0;
                        if (last_pat_c) begin
                            // Final capture: score the completed table and pulse done
                            state_q   <= S_DONE;
                            pass_q    <= (table_d == EXPECTED);
                            pattern_q <= '0;
                            vld_q     <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            pattern_q <= pattern_q + N_IN'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    pattern_q <= '0;
                    cnt_q     <= '0;
                    vld_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pattern_o     = pattern_q;
    assign pattern_vld_o = vld_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign table_o       = table_q;
    assign pass_o        = pass_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
